pcpi_mext_dispatch: RTL and testbench
=====================================

Name: pcpi_mext_dispatch

Overview:
- Upstream stage between the CPU core's PCPI port and the two M-extension coprocessors: the multiplier (funct3[2]=0) and the divider (funct3[2]=1).
- Decodes each PCPI request, registers its operands, and issues it to the selected slave.
- Waits for the slave's ready, registers the result, and returns it to the core with a one-cycle ready pulse.
- Adds a watchdog timeout and clean abort handling.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles a slave may take before the dispatcher forces a response.
- CNT_W, 32: width of the statistics counters (only used when PCPI_DISPATCH_STATS_EN is defined).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- pcpi_valid/pcpi_insn/pcpi_rs1/pcpi_rs2  in  1/32/32/32  core request
- pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready  out  1/32/1/1  core response
- slv_insn/slv_rs1/slv_rs2  out  32/32/32  registered operands, shared by both slaves
- mul_valid, div_valid  out  1 each  per-slave request
- mul_wr/mul_rd/mul_wait/mul_ready  in  1/32/1/1  multiplier response
- div_wr/div_rd/div_wait/div_ready  in  1/32/1/1  divider response
- pcpi_timeout  out  1  one-cycle pulse when a forced timeout response is issued

Behaviour:
- M-ext match: insn[6:0]==7'b0110011 and insn[31:25]==7'b0000001. Any other instruction is ignored: no wait, no ready, all outputs stay 0.
- Reset: state IDLE. All outputs 0, including slv_* registers and the timeout counter. Reset mid-operation abandons the operation immediately; no response is issued.
- IDLE:
  - On pcpi_valid and M-ext match: latch insn/rs1/rs2 into slv_*, latch sel=insn[14], clear the counter, go to BUSY.
  - mul_ready/div_ready are ignored in IDLE.
- BUSY:
  - Outputs: pcpi_wait=1; mul_valid = ~sel; div_valid = sel (registered, asserted from the cycle after acceptance).
  - Counter increments each cycle.
  - If the selected slave's ready=1: capture its wr and rd, deassert its valid on the next edge, go to RESP.
  - If counter == TIMEOUT_CYCLES-1 with no ready: capture wr=0, rd=0, set the timeout flag, go to RESP.
  - Ready and timeout in the same cycle: ready wins; no timeout is flagged.
  - The unselected slave's ready is ignored.
  - If pcpi_valid drops (core abort): deassert slave valid, go to IDLE, no response.
- RESP (exactly 1 cycle):
  - pcpi_ready=1, pcpi_wr and pcpi_rd driven from the captured values, pcpi_wait=0.
  - pcpi_timeout=1 if the timeout flag is set.
  - Go to DRAIN.
- DRAIN: all outputs 0. Stay until pcpi_valid==0, then go to IDLE. This prevents re-issuing the request the core still holds.
- pcpi_rd and pcpi_wr are 0 in every cycle other than RESP.
- Latency:
  - Slave valid rises 1 cycle after the core's valid is sampled.
  - pcpi_ready rises 1 cycle after the slave's ready.
  - Total core-visible latency = slave latency + 2.

Optional Feature:
- Macro: PCPI_DISPATCH_STATS_EN.
- Defined: adds outputs stat_mul_ops, stat_div_ops, stat_busy_cycles, stat_timeouts, each CNT_W bits.
  - Op counters increment on entry to RESP.
  - Busy counter increments every cycle spent in BUSY.
  - Timeout counter increments on each pcpi_timeout pulse.
  - All counters clear on reset and saturate at all-ones.
- Undefined: these ports and their logic are absent. Core-side behaviour is identical either way.

Decomposition:
- Shared package pcpi_pkg holds:
  - OPCODE_OP (7'b0110011) and FUNCT7_MULDIV (7'b0000001)
  - funct3 codes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
  - state typedef IDLE/BUSY/RESP/DRAIN
- One sub-module, pcpi_mext_decode: combinational match plus sel extraction. It is reused by the coprocessors.

Test Plan:
- DIV, rs1=20, rs2=3, funct3=100, stub divider ready after 5 cycles:
  - div_valid high and mul_valid low throughout; pcpi_ready pulses once at slave_ready+1; pcpi_rd=6, pcpi_wr=1.
- MUL, rs1=7, rs2=-3, funct3=000, stub multiplier ready after 2 cycles:
  - Only mul_valid asserted; pcpi_rd=0xFFFFFFEB.
- ADD instruction (funct7=0) with pcpi_valid held 20 cycles:
  - pcpi_wait, pcpi_ready, mul_valid, div_valid all 0 throughout.
- TIMEOUT_CYCLES=8, divider never ready:
  - pcpi_ready with wr=0 and rd=0 exactly 9 cycles after acceptance; pcpi_timeout single pulse.
  - Core holds valid 3 more cycles: DRAIN holds and no re-issue occurs.
- Core drops pcpi_valid in the 3rd BUSY cycle:
  - Slave valid low next cycle; no pcpi_ready.
  - A later divider ready pulse is ignored.
  - A following DIVU 0xFFFFFFFF/2 returns 0x7FFFFFFF.
- reset asserted mid-BUSY:
  - Next cycle all outputs 0 and state IDLE.
  - With PCPI_DISPATCH_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI M-extension dispatcher and its coprocessors.
package pcpi_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Response payload returned by either slave.
  typedef struct packed {
    logic            wr;
    logic [XLEN-1:0] rd;
  } pcpi_resp_t;

  // funct3[2] selects the divider; shared so coprocessors decode identically.
  function automatic logic f3_is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/pcpi_mext_decode.sv
// Combinational M-extension match and slave select (0 = multiplier, 1 = divider).
module pcpi_mext_decode
  import pcpi_pkg::*;
(
  input  logic [XLEN-1:0] insn,
  output logic            is_mext_c,
  output logic            sel_c
);

  always_comb begin
    is_mext_c = (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
    sel_c     = f3_is_div(insn[14:12]);
  end

endmodule

// File: rtl/pcpi_mext_dispatch.sv
// PCPI dispatcher routing M-extension ops to the multiplier or divider, with watchdog.
// Optional statistics counters are built when PCPI_DISPATCH_STATS_EN is defined.
module pcpi_mext_dispatch
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcpi_valid,
  input  logic [XLEN-1:0]  pcpi_insn,
  input  logic [XLEN-1:0]  pcpi_rs1,
  input  logic [XLEN-1:0]  pcpi_rs2,
  output logic             pcpi_wr,
  output logic [XLEN-1:0]  pcpi_rd,
  output logic             pcpi_wait,
  output logic             pcpi_ready,
  output logic [XLEN-1:0]  slv_insn,
  output logic [XLEN-1:0]  slv_rs1,
  output logic [XLEN-1:0]  slv_rs2,
  output logic             mul_valid,
  output logic             div_valid,
  input  logic             mul_wr,
  input  logic [XLEN-1:0]  mul_rd,
  input  logic             mul_wait,
  input  logic             mul_ready,
  input  logic             div_wr,
  input  logic [XLEN-1:0]  div_rd,
  input  logic             div_wait,
  input  logic             div_ready,
`ifdef PCPI_DISPATCH_STATS_EN
  output logic [CNT_W-1:0] stat_mul_ops,
  output logic [CNT_W-1:0] stat_div_ops,
  output logic [CNT_W-1:0] stat_busy_cycles,
  output logic [CNT_W-1:0] stat_timeouts,
`endif
  output logic             pcpi_timeout
);

  localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_sel;
  logic            w_accept;

  logic            r_pcpi_wr,      w_pcpi_wr_nxt;
  logic [XLEN-1:0] r_pcpi_rd,      w_pcpi_rd_nxt;
  logic            r_pcpi_wait,    w_pcpi_wait_nxt;
  logic            r_pcpi_ready,   w_pcpi_ready_nxt;
  logic            r_pcpi_timeout, w_pcpi_timeout_nxt;
  logic            r_mul_valid,    w_mul_valid_nxt;
  logic            r_div_valid,    w_div_valid_nxt;
  logic [XLEN-1:0] r_slv_insn;
  logic [XLEN-1:0] r_slv_rs1;
  logic [XLEN-1:0] r_slv_rs2;

  logic            w_is_mext_c;
  logic            w_sel_c;
  logic            w_slv_ready;
  pcpi_resp_t      w_slv_resp;

  pcpi_mext_decode u_decode (
    .insn      (pcpi_insn),
    .is_mext_c (w_is_mext_c),
    .sel_c     (w_sel_c)
  );

  // Only the slave that owns the operation can complete it.
  always_comb begin
    w_slv_ready   = r_sel ? div_ready : mul_ready;
    w_slv_resp.wr = r_sel ? div_wr    : mul_wr;
    w_slv_resp.rd = r_sel ? div_rd    : mul_rd;
  end

  // Next-state and next-output decode; outputs are the registered image of these.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_accept           = 1'b0;
    w_pcpi_wr_nxt      = 1'b0;
    w_pcpi_rd_nxt      = '0;
    w_pcpi_wait_nxt    = 1'b0;
    w_pcpi_ready_nxt   = 1'b0;
    w_pcpi_timeout_nxt = 1'b0;
    w_mul_valid_nxt    = 1'b0;
    w_div_valid_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (pcpi_valid && w_is_mext_c) begin
          w_state_nxt     = ST_BUSY;
          w_accept        = 1'b1;
          w_cnt_nxt       = '0;
          w_pcpi_wait_nxt = 1'b1;
          w_mul_valid_nxt = ~w_sel_c;
          w_div_valid_nxt = w_sel_c;
        end
      end

      ST_BUSY: begin
        w_cnt_nxt = r_cnt + TO_W'(1);
        if (!pcpi_valid) begin
          // Core abort: drop the request silently.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_slv_ready) begin
          w_state_nxt      = ST_RESP;
          w_pcpi_ready_nxt = 1'b1;
          w_pcpi_wr_nxt    = w_slv_resp.wr;
          w_pcpi_rd_nxt    = w_slv_resp.rd;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt        = ST_RESP;
          w_pcpi_ready_nxt   = 1'b1;
          w_pcpi_timeout_nxt = 1'b1;
        end else begin
          w_pcpi_wait_nxt = 1'b1;
          w_mul_valid_nxt = ~r_sel;
          w_div_valid_nxt = r_sel;
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_DRAIN;
      end

      ST_DRAIN: begin
        // Hold until the core releases the request it was just answered on.
        if (!pcpi_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_sel          <= 1'b0;
      r_pcpi_wr      <= 1'b0;
      r_pcpi_rd      <= '0;
      r_pcpi_wait    <= 1'b0;
      r_pcpi_ready   <= 1'b0;
      r_pcpi_timeout <= 1'b0;
      r_mul_valid    <= 1'b0;
      r_div_valid    <= 1'b0;
      r_slv_insn     <= '0;
      r_slv_rs1      <= '0;
      r_slv_rs2      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_pcpi_wr      <= w_pcpi_wr_nxt;
      r_pcpi_rd      <= w_pcpi_rd_nxt;
      r_pcpi_wait    <= w_pcpi_wait_nxt;
      r_pcpi_ready   <= w_pcpi_ready_nxt;
      r_pcpi_timeout <= w_pcpi_timeout_nxt;
      r_mul_valid    <= w_mul_valid_nxt;
      r_div_valid    <= w_div_valid_nxt;
      if (w_accept) begin
        r_slv_insn <= pcpi_insn;
        r_slv_rs1  <= pcpi_rs1;
        r_slv_rs2  <= pcpi_rs2;
        r_sel      <= w_sel_c;
      end
    end
  end

  assign pcpi_wr      = r_pcpi_wr;
  assign pcpi_rd      = r_pcpi_rd;
  assign pcpi_wait    = r_pcpi_wait;
  assign pcpi_ready   = r_pcpi_ready;
  assign pcpi_timeout = r_pcpi_timeout;
  assign mul_valid    = r_mul_valid;
  assign div_valid    = r_div_valid;
  assign slv_insn     = r_slv_insn;
  assign slv_rs1      = r_slv_rs1;
  assign slv_rs2      = r_slv_rs2;

`ifdef PCPI_DISPATCH_STATS_EN
  logic [CNT_W-1:0] r_stat_mul_ops;
  logic [CNT_W-1:0] r_stat_div_ops;
  logic [CNT_W-1:0] r_stat_busy_cycles;
  logic [CNT_W-1:0] r_stat_timeouts;
  logic             w_resp_entry;

  assign w_resp_entry = (r_state == ST_BUSY) && (w_state_nxt == ST_RESP);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_mul_ops     <= '0;
      r_stat_div_ops     <= '0;
      r_stat_busy_cycles <= '0;
      r_stat_timeouts    <= '0;
    end else begin
      if (w_resp_entry && !r_sel && (r_stat_mul_ops != '1)) begin
        r_stat_mul_ops <= r_stat_mul_ops + CNT_W'(1);
      end
      if (w_resp_entry && r_sel && (r_stat_div_ops != '1)) begin
        r_stat_div_ops <= r_stat_div_ops + CNT_W'(1);
      end
      if ((r_state == ST_BUSY) && (r_stat_busy_cycles != '1)) begin
        r_stat_busy_cycles <= r_stat_busy_cycles + CNT_W'(1);
      end
      if (w_pcpi_timeout_nxt && (r_stat_timeouts != '1)) begin
        r_stat_timeouts <= r_stat_timeouts + CNT_W'(1);
      end
    end
  end

  assign stat_mul_ops     = r_stat_mul_ops;
  assign stat_div_ops     = r_stat_div_ops;
  assign stat_busy_cycles = r_stat_busy_cycles;
  assign stat_timeouts    = r_stat_timeouts;

  logic w_unused;
  assign w_unused = ^{mul_wait, div_wait};
`else
  logic w_unused;
  assign w_unused = ^{mul_wait, div_wait, (CNT_W == 0)};
`endif

endmodule

// File: tb/tb_pcpi_mext_dispatch.sv
// Directed self-checking bench for pcpi_mext_dispatch with stub multiplier/divider.
module tb_pcpi_mext_dispatch;

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout;
  logic [31:0] pcpi_rd;
  logic [31:0] slv_insn, slv_rs1, slv_rs2;
  logic        mul_valid, div_valid;
  logic        mul_wr, mul_wait, mul_ready;
  logic [31:0] mul_rd;
  logic        div_wr, div_wait, div_ready;
  logic [31:0] div_rd;
`ifdef PCPI_DISPATCH_STATS_EN
  logic [31:0] stat_mul_ops, stat_div_ops, stat_busy_cycles, stat_timeouts;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // Stub controls, written only by the main sequence.
  logic mul_en, div_en, div_inject;
  int   mul_lat, div_lat;
  int   mul_cnt, div_cnt;

  pcpi_mext_dispatch #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .slv_insn(slv_insn), .slv_rs1(slv_rs1), .slv_rs2(slv_rs2),
    .mul_valid(mul_valid), .div_valid(div_valid),
    .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
`ifdef PCPI_DISPATCH_STATS_EN
    .stat_mul_ops(stat_mul_ops), .stat_div_ops(stat_div_ops),
    .stat_busy_cycles(stat_busy_cycles), .stat_timeouts(stat_timeouts),
`endif
    .pcpi_timeout(pcpi_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] div_model(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    case (insn[13:12])
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Stub divider: ready for one cycle after div_lat cycles of div_valid.
  always @(negedge clk) begin
    if (div_inject) begin
      div_ready = 1'b1;
      div_wr    = 1'b1;
      div_rd    = 32'hDEAD_BEEF;
    end else if (div_en && div_valid && !div_ready) begin
      div_cnt = div_cnt + 1;
      if (div_cnt == div_lat) begin
        div_ready = 1'b1;
        div_wr    = 1'b1;
        div_rd    = div_model(slv_insn, slv_rs1, slv_rs2);
      end
    end else begin
      div_ready = 1'b0;
      div_wr    = 1'b0;
      div_rd    = 32'd0;
      div_cnt   = 0;
    end
  end

  // Stub multiplier: low product after mul_lat cycles of mul_valid.
  always @(negedge clk) begin
    if (mul_en && mul_valid && !mul_ready) begin
      mul_cnt = mul_cnt + 1;
      if (mul_cnt == mul_lat) begin
        mul_ready = 1'b1;
        mul_wr    = 1'b1;
        mul_rd    = slv_rs1 * slv_rs2;
      end
    end else begin
      mul_ready = 1'b0;
      mul_wr    = 1'b0;
      mul_rd    = 32'd0;
      mul_cnt   = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({pcpi_wait, pcpi_ready, mul_valid, div_valid, pcpi_timeout});
  endfunction

  // Issue one request and check every cycle: c = cycles after the accepting edge.
  task automatic run_txn(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int busy_last, input int ready_cyc,
                         input logic sel, input logic exp_to, input logic [31:0] exp_rd,
                         input logic exp_wr, input int release_cyc, input int ncyc);
    logic busy, rdy;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      busy = (c <= busy_last);
      rdy  = (c == ready_cyc);
      chk($sformatf("%s_flags_c%0d", tag, c), flags(),
          32'({busy, rdy, busy & ~sel, busy & sel, rdy & exp_to}));
      chk($sformatf("%s_rd_c%0d", tag, c), pcpi_rd, rdy ? exp_rd : 32'd0);
      chk($sformatf("%s_wr_c%0d", tag, c), 32'(pcpi_wr), rdy ? 32'(exp_wr) : 32'd0);
      if (c == 1 && busy_last >= 1) begin
        chk($sformatf("%s_slv_insn", tag), slv_insn, insn);
        chk($sformatf("%s_slv_rs1", tag), slv_rs1, rs1);
        chk($sformatf("%s_slv_rs2", tag), slv_rs2, rs2);
      end
      if (c == release_cyc) pcpi_valid = 1'b0;
    end
    pcpi_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, flags(), 32'd0);
    chk({tag, "_rd"}, pcpi_rd, 32'd0);
    chk({tag, "_wr"}, 32'(pcpi_wr), 32'd0);
    chk({tag, "_slv_insn"}, slv_insn, 32'd0);
    chk({tag, "_slv_rs1"}, slv_rs1, 32'd0);
    chk({tag, "_slv_rs2"}, slv_rs2, 32'd0);
`ifdef PCPI_DISPATCH_STATS_EN
    chk({tag, "_st_mul"}, stat_mul_ops, 32'd0);
    chk({tag, "_st_div"}, stat_div_ops, 32'd0);
    chk({tag, "_st_busy"}, stat_busy_cycles, 32'd0);
    chk({tag, "_st_to"}, stat_timeouts, 32'd0);
`endif
  endtask

  initial begin
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    mul_wait   = 1'b0;
    div_wait   = 1'b0;
    mul_en     = 1'b1;
    div_en     = 1'b1;
    div_inject = 1'b0;
    mul_lat    = 2;
    div_lat    = 5;
    mul_ready  = 1'b0; mul_wr = 1'b0; mul_rd = 32'd0; mul_cnt = 0;
    div_ready  = 1'b0; div_wr = 1'b0; div_rd = 32'd0; div_cnt = 0;

    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // DIV 20/3, divider answers after 5 cycles.
    div_lat = 5;
    run_txn("div", mk_insn(7'b0000001, 3'b100), 32'd20, 32'd3,
            5, 6, 1'b1, 1'b0, 32'd6, 1'b1, 6, 9);

    // MUL 7 * -3, multiplier answers after 2 cycles.
    mul_lat = 2;
    run_txn("mul", mk_insn(7'b0000001, 3'b000), 32'd7, 32'hFFFF_FFFD,
            2, 3, 1'b0, 1'b0, 32'hFFFF_FFEB, 1'b1, 3, 6);

    // ADD is not an M-ext op: no activity while valid is held.
    run_txn("add", mk_insn(7'b0000000, 3'b000), 32'd5, 32'd6,
            0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 20, 21);

    // Divider never answers: forced response 9 cycles after acceptance, then DRAIN.
    div_en = 1'b0;
    run_txn("tmo", mk_insn(7'b0000001, 3'b100), 32'd20, 32'd3,
            8, 9, 1'b1, 1'b1, 32'd0, 1'b0, 12, 15);

    // Ready arrives in the final watchdog cycle: the real result wins.
    div_en  = 1'b1;
    div_lat = 8;
    run_txn("edge", mk_insn(7'b0000001, 3'b100), 32'd20, 32'd3,
            8, 9, 1'b1, 1'b0, 32'd6, 1'b1, 9, 11);

    // Core aborts during the 3rd BUSY cycle.
    div_en = 1'b0;
    run_txn("abort", mk_insn(7'b0000001, 3'b100), 32'd20, 32'd3,
            3, 0, 1'b1, 1'b0, 32'd0, 1'b0, 3, 5);

    // Stray divider ready while idle must be ignored.
    div_inject = 1'b1;
    step();
    div_inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stray_flags_%0d", i), flags(), 32'd0);
      chk($sformatf("stray_rd_%0d", i), pcpi_rd, 32'd0);
    end

    // DIVU 0xFFFFFFFF / 2.
    div_en  = 1'b1;
    div_lat = 3;
    run_txn("divu", mk_insn(7'b0000001, 3'b101), 32'hFFFF_FFFF, 32'd2,
            3, 4, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 4, 6);

`ifdef PCPI_DISPATCH_STATS_EN
    chk("st_mul", stat_mul_ops, 32'd1);
    chk("st_div", stat_div_ops, 32'd4);
    chk("st_busy", stat_busy_cycles, 32'd29);
    chk("st_to", stat_timeouts, 32'd1);
`endif

    // Reset in the middle of a BUSY divide.
    div_en     = 1'b0;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, 3'b100);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    step();
    step();
    step();
    chk("pre_rst_wait", 32'(pcpi_wait), 32'd1);
    reset = 1'b1;
    step();
    chk_all_zero("midrst");
    reset      = 1'b0;
    pcpi_valid = 1'b0;
    step();
    chk("post_rst_flags", flags(), 32'd0);
    chk("post_rst_rd", pcpi_rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
